// File: rtl/imm_pkg.sv
// Shared definitions for the LEGv8 immediate generator: format codes,
// 11-bit opcode patterns with their don't-care masks, and the opcode decoder.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_D    = 3'd1,
    FMT_CB   = 3'd2,
    FMT_B    = 3'd3,
    FMT_I    = 3'd4,
    FMT_IW   = 3'd5
  } fmt_t;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_CBNZ = 11'b10110101000;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_BL   = 11'b10010100000;
  localparam logic [10:0] OP_ADDI = 11'b10010001000;
  localparam logic [10:0] OP_SUBI = 11'b11010001000;
  localparam logic [10:0] OP_MOVZ = 11'b11010010100;

  // Mask bits set to 0 mark opcode bits that belong to the immediate field.
  localparam logic [10:0] MASK_D  = 11'b11111111111;
  localparam logic [10:0] MASK_CB = 11'b11111111000;
  localparam logic [10:0] MASK_B  = 11'b11111100000;
  localparam logic [10:0] MASK_I  = 11'b11111111110;
  localparam logic [10:0] MASK_IW = 11'b11111111100;

  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] pat,
                                    input logic [10:0] mask);
    return (op & mask) == pat;
  endfunction

  function automatic fmt_t decode_fmt(input logic [10:0] op);
    fmt_t f;
    f = FMT_NONE;
    if (op_match(op, OP_LDUR, MASK_D) || op_match(op, OP_STUR, MASK_D))
      f = FMT_D;
    else if (op_match(op, OP_CBZ, MASK_CB) || op_match(op, OP_CBNZ, MASK_CB))
      f = FMT_CB;
    else if (op_match(op, OP_B, MASK_B) || op_match(op, OP_BL, MASK_B))
      f = FMT_B;
    else if (op_match(op, OP_ADDI, MASK_I) || op_match(op, OP_SUBI, MASK_I))
      f = FMT_I;
    else if (op_match(op, OP_MOVZ, MASK_IW))
      f = FMT_IW;
    return f;
  endfunction

endpackage

// File: rtl/imm_ext.sv
// Combinational immediate extraction: turns an instruction word plus its
// decoded format into the N-bit extended immediate and the illegal flag.
module imm_ext
  import imm_pkg::*;
#(
  parameter int N        = 64,
  parameter bit BR_SHIFT = 1'b0
) (
  input  logic [31:0]  instr,
  input  fmt_t         fmt,
  output logic [N-1:0] imm,
  output logic         illegal
);

  logic [63:0] wide;
  logic        unused_hi;

  always_comb begin
    wide    = '0;
    illegal = 1'b0;
    case (fmt)
      FMT_D:  wide = {{55{instr[20]}}, instr[20:12]};
      FMT_CB: begin
        wide = {{45{instr[23]}}, instr[23:5]};
        if (BR_SHIFT) wide = wide << 2;
      end
      FMT_B:  begin
        wide = {{38{instr[25]}}, instr[25:0]};
        if (BR_SHIFT) wide = wide << 2;
      end
      FMT_I:  wide = {{52{instr[21]}}, instr[21:10]};
      FMT_IW: begin
        // A 32-bit result cannot hold halfword positions 2 and 3.
        if (N == 32 && instr[22]) illegal = 1'b1;
        else wide = {48'b0, instr[20:5]} << {instr[22:21], 4'b0000};
      end
      default: illegal = 1'b1;
    endcase
  end

  // Bits above N-1 are simply dropped, which is the intended overflow rule.
  assign imm       = wide[N-1:0];
  assign unused_hi = ^{instr[31:26], wide};

endmodule

// File: rtl/imm_gen.sv
// Two-stage LEGv8 immediate generator: S1 holds the instruction and decoded
// format, S2 holds the extended immediate, format and illegal flag.
module imm_gen
  import imm_pkg::*;
#(
  parameter int N        = 64,
  parameter bit BR_SHIFT = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  instr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] imm,
  output logic [2:0]   fmt,
  output logic         illegal
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a source holds its data stable while valid=1 and ready=0, and
  // valid never depends combinationally on ready.

  logic         s1_valid;
  logic [31:0]  s1_instr;
  fmt_t         s1_fmt;
  logic         s2_valid;
  logic [N-1:0] s2_imm;
  fmt_t         s2_fmt;
  logic         s2_illegal;

  fmt_t         in_fmt;
  logic         s2_can_accept;
  logic [N-1:0] ext_imm;
  logic         ext_illegal;

  assign in_fmt        = decode_fmt(instr[31:21]);
  assign s2_can_accept = !s2_valid || out_ready;
  assign in_ready      = !reset && (!s1_valid || s2_can_accept);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_instr <= '0;
      s1_fmt   <= FMT_NONE;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_instr <= instr;
        s1_fmt   <= in_fmt;
      end
    end
  end

  imm_ext #(
    .N        (N),
    .BR_SHIFT (BR_SHIFT)
  ) u_ext (
    .instr   (s1_instr),
    .fmt     (s1_fmt),
    .imm     (ext_imm),
    .illegal (ext_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid   <= 1'b0;
      s2_imm     <= '0;
      s2_fmt     <= FMT_NONE;
      s2_illegal <= 1'b0;
    end else if (s2_can_accept) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_imm     <= ext_imm;
        s2_fmt     <= s1_fmt;
        s2_illegal <= ext_illegal;
      end
    end
  end

  assign out_valid = s2_valid;
  assign imm       = s2_imm;
  assign fmt       = s2_fmt;
  assign illegal   = s2_illegal;

endmodule

// File: tb/tb_imm_gen.sv
// Bench for imm_gen: three instances (64-bit, 64-bit with branch shift,
// 32-bit) share one stimulus stream and are checked against an in-bench model.
module tb_imm_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = '0;

  logic        r64_in_ready, r64_out_valid, r64_illegal;
  logic [63:0] r64_imm;
  logic [2:0]  r64_fmt;
  logic        s64_in_ready, s64_out_valid, s64_illegal;
  logic [63:0] s64_imm;
  logic [2:0]  s64_fmt;
  logic        r32_in_ready, r32_out_valid, r32_illegal;
  logic [31:0] r32_imm;
  logic [2:0]  r32_fmt;

  always #5 clk = ~clk;

  imm_gen #(.N(64), .BR_SHIFT(1'b0)) u_r64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r64_in_ready),
    .instr(instr), .out_valid(r64_out_valid), .out_ready(out_ready),
    .imm(r64_imm), .fmt(r64_fmt), .illegal(r64_illegal));

  imm_gen #(.N(64), .BR_SHIFT(1'b1)) u_s64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s64_in_ready),
    .instr(instr), .out_valid(s64_out_valid), .out_ready(out_ready),
    .imm(s64_imm), .fmt(s64_fmt), .illegal(s64_illegal));

  imm_gen #(.N(32), .BR_SHIFT(1'b0)) u_r32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(r32_in_ready),
    .instr(instr), .out_valid(r32_out_valid), .out_ready(out_ready),
    .imm(r32_imm), .fmt(r32_fmt), .illegal(r32_illegal));

  int n_tests = 0;
  int n_fail  = 0;
  int out_cnt = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  function automatic exp_t model(input logic [31:0] x, input int n, input bit brs);
    exp_t        e;
    logic [10:0] op;
    longint      v;
    logic [63:0] u;
    op = x[31:21];
    v  = 0;
    u  = '0;
    e.fmt = 3'd0;
    e.ill = 1'b0;
    if (op == 11'h7C2 || op == 11'h7C0) begin
      e.fmt = 3'd1;
      v = longint'($signed(x[20:12]));
      u = v;
    end else if (op[10:3] == 8'hB4 || op[10:3] == 8'hB5) begin
      e.fmt = 3'd2;
      v = longint'($signed(x[23:5]));
      if (brs) v = v * 64'sd4;
      u = v;
    end else if (op[10:5] == 6'b000101 || op[10:5] == 6'b100101) begin
      e.fmt = 3'd3;
      v = longint'($signed(x[25:0]));
      if (brs) v = v * 64'sd4;
      u = v;
    end else if (op[10:1] == 10'b1001000100 || op[10:1] == 10'b1101000100) begin
      e.fmt = 3'd4;
      v = longint'($signed(x[21:10]));
      u = v;
    end else if (op[10:2] == 9'b110100101) begin
      e.fmt = 3'd5;
      if (n == 32 && x[22]) e.ill = 1'b1;
      else u = {48'b0, x[20:5]} << {x[22:21], 4'b0000};
    end else begin
      e.ill = 1'b1;
    end
    if (n == 32) u[63:32] = '0;
    e.imm = u;
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: return {11'b11111000010, r[20:0]};
      1: return {11'b11111000000, r[20:0]};
      2: return {8'b10110100, r[23:0]};
      3: return {8'b10110101, r[23:0]};
      4: return {6'b000101, r[25:0]};
      5: return {6'b100101, r[25:0]};
      6: return {10'b1001000100, r[21:0]};
      7: return {10'b1101000100, r[21:0]};
      8: return {9'b110100101, r[22:0]};
      default: return r;
    endcase
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [31:0] exp_q[$];
  bit          stalled = 1'b0;
  logic [63:0] hold_imm;
  logic [2:0]  hold_fmt;
  logic        hold_ill;
  logic [31:0] sb_x;
  exp_t        sb_e;

  always @(negedge clk) begin
    if (!reset) begin
      if (in_valid && r64_in_ready) exp_q.push_back(instr);
      chk("ready_agree", 64'({r32_in_ready, s64_in_ready}), 64'({2{r64_in_ready}}));
      chk("valid_agree", 64'({r32_out_valid, s64_out_valid}), 64'({2{r64_out_valid}}));
      if (stalled) begin
        chk("hold_valid", 64'(r64_out_valid), 64'(1));
        chk("hold_imm", r64_imm, hold_imm);
        chk("hold_fmt", 64'(r64_fmt), 64'(hold_fmt));
        chk("hold_ill", 64'(r64_illegal), 64'(hold_ill));
      end
      if (r64_out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) begin
          chk("spurious_out", 64'(1), 64'(0));
        end else begin
          sb_x = exp_q.pop_front();
          sb_e = model(sb_x, 64, 1'b0);
          chk("r64_imm", r64_imm, sb_e.imm);
          chk("r64_fmt", 64'(r64_fmt), 64'(sb_e.fmt));
          chk("r64_ill", 64'(r64_illegal), 64'(sb_e.ill));
          sb_e = model(sb_x, 64, 1'b1);
          chk("s64_imm", s64_imm, sb_e.imm);
          chk("s64_fmt", 64'(s64_fmt), 64'(sb_e.fmt));
          chk("s64_ill", 64'(s64_illegal), 64'(sb_e.ill));
          sb_e = model(sb_x, 32, 1'b0);
          chk("r32_imm", 64'(r32_imm), sb_e.imm);
          chk("r32_fmt", 64'(r32_fmt), 64'(sb_e.fmt));
          chk("r32_ill", 64'(r32_illegal), 64'(sb_e.ill));
        end
      end
      stalled  = r64_out_valid && !out_ready;
      hold_imm = r64_imm;
      hold_fmt = r64_fmt;
      hold_ill = r64_illegal;
    end else begin
      stalled = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] x, input logic r);
    in_valid  = v;
    instr     = x;
    out_ready = r;
  endtask

  // ---------------- main sequence ----------------
  exp_t pin;
  int   base;
  bit   acc;

  initial begin
    // Model pins against hand-computed values.
    pin = model(32'hF85FF000, 64, 1'b0);
    chk("pin_ldur", pin.imm, 64'hFFFFFFFFFFFFFFFF);
    pin = model(32'hB4800000, 64, 1'b1);
    chk("pin_cbz_shift", pin.imm, 64'hFFFFFFFFFFF00000);
    pin = model(32'hD2F579A0, 64, 1'b0);
    chk("pin_movz64", pin.imm, 64'hABCD000000000000);
    pin = model(32'hD2F579A0, 32, 1'b0);
    chk("pin_movz32_ill", 64'(pin.ill), 64'(1));

    // Reset state.
    #1 reset = 1'b1;
    #2;
    chk("rst_out_valid", 64'(r64_out_valid), 64'(0));
    chk("rst_imm", r64_imm, 64'(0));
    chk("rst_fmt", 64'(r64_fmt), 64'(0));
    chk("rst_ill", 64'(r64_illegal), 64'(0));
    chk("rst_in_ready", 64'(r64_in_ready), 64'(0));
    repeat (2) cyc();
    reset = 1'b0;
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    chk("in_ready_after_rst", 64'(r64_in_ready), 64'(1));
    cyc();

    // LDUR latency.
    drive(1'b1, 32'hF85FF000, 1'b1);
    cyc();
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    chk("ldur_lat1_valid", 64'(r64_out_valid), 64'(0));
    cyc();
    @(negedge clk);
    chk("ldur_valid", 64'(r64_out_valid), 64'(1));
    chk("ldur_imm", r64_imm, 64'hFFFFFFFFFFFFFFFF);
    chk("ldur_fmt", 64'(r64_fmt), 64'(1));
    chk("ldur_ill", 64'(r64_illegal), 64'(0));
    repeat (2) cyc();

    // CBZ with and without branch shift.
    drive(1'b1, 32'hB4800000, 1'b1);
    cyc();
    drive(1'b0, '0, 1'b1);
    cyc();
    @(negedge clk);
    chk("cbz_imm", r64_imm, 64'hFFFFFFFFFFFC0000);
    chk("cbz_imm_shift", s64_imm, 64'hFFFFFFFFFFF00000);
    chk("cbz_fmt", 64'(r64_fmt), 64'(2));
    chk("cbz_fmt_shift", 64'(s64_fmt), 64'(2));
    repeat (2) cyc();

    // MOVZ in 64 and 32 bits.
    drive(1'b1, 32'hD2F579A0, 1'b1);
    cyc();
    drive(1'b0, '0, 1'b1);
    cyc();
    @(negedge clk);
    chk("movz64_imm", r64_imm, 64'hABCD000000000000);
    chk("movz64_fmt", 64'(r64_fmt), 64'(5));
    chk("movz64_ill", 64'(r64_illegal), 64'(0));
    chk("movz32_imm", 64'(r32_imm), 64'(0));
    chk("movz32_ill", 64'(r32_illegal), 64'(1));
    chk("movz32_fmt", 64'(r32_fmt), 64'(5));
    repeat (2) cyc();

    // Illegal followed back-to-back by B.
    drive(1'b1, 32'h00000000, 1'b1);
    cyc();
    drive(1'b1, 32'h17FFFFFF, 1'b1);
    cyc();
    drive(1'b0, '0, 1'b1);
    @(negedge clk);
    chk("ill_valid", 64'(r64_out_valid), 64'(1));
    chk("ill_fmt", 64'(r64_fmt), 64'(0));
    chk("ill_flag", 64'(r64_illegal), 64'(1));
    chk("ill_imm", r64_imm, 64'(0));
    cyc();
    @(negedge clk);
    chk("b_valid", 64'(r64_out_valid), 64'(1));
    chk("b_imm", r64_imm, 64'hFFFFFFFFFFFFFFFF);
    chk("b_fmt", 64'(r64_fmt), 64'(3));
    chk("b_imm_shift", s64_imm, 64'hFFFFFFFFFFFFFFFC);
    chk("b_imm32", 64'(r32_imm), 64'hFFFFFFFF);
    repeat (2) cyc();

    // Backpressure: three back-to-back instructions against a stalled sink.
    base = out_cnt;
    drive(1'b1, 32'h91000C20, 1'b0);
    cyc();
    drive(1'b1, 32'hB4800000, 1'b0);
    cyc();
    drive(1'b1, 32'h17FFFFFF, 1'b0);
    @(negedge clk);
    chk("bp_in_ready_low", 64'(r64_in_ready), 64'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_first_valid", 64'(r64_out_valid), 64'(1));
      chk("bp_first_imm", r64_imm, 64'd3);
      cyc();
    end
    out_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      @(negedge clk);
      acc = r64_in_ready;
      cyc();
    end
    chk("bp_third_accepted", 64'(acc), 64'(1));
    in_valid = 1'b0;
    for (int i = 0; i < 10 && out_cnt < base + 3; i++) cyc();
    chk("bp_out_count", 64'(out_cnt - base), 64'(3));

    // Reset with two instructions in flight.
    drive(1'b1, 32'hF85FF000, 1'b0);
    cyc();
    drive(1'b1, 32'h91000C20, 1'b0);
    cyc();
    drive(1'b0, '0, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(r64_out_valid), 64'(0));
    chk("mid_rst_imm", r64_imm, 64'(0));
    chk("mid_rst_fmt", 64'(r64_fmt), 64'(0));
    chk("mid_rst_in_ready", 64'(r64_in_ready), 64'(0));
    exp_q.delete();
    repeat (2) cyc();
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready_after", 64'(r64_in_ready), 64'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale_out", 64'(r64_out_valid), 64'(0));
      cyc();
    end

    // Randomized traffic with random backpressure.
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      acc = in_valid && r64_in_ready;
      cyc();
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        instr    = gen_instr();
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain.
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc();
    repeat (2) cyc();
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, limit %0d ns", 1_000_000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
